// File: rtl/accel_pkg.sv
// Shared types and helpers for the accelerometer tilt conditioning path.
package accel_pkg;

    localparam int G_W = 10;

    typedef enum logic {
        RUN = 1'b0,
        CAL = 1'b1
    } state_t;

    // Saturate an 11-bit signed difference into the 10-bit signed range.
    function automatic logic signed [G_W-1:0] sat10(input logic signed [G_W:0] v);
        if (v[G_W] != v[G_W-1])
            return v[G_W] ? {1'b1, {(G_W-1){1'b0}}} : {1'b0, {(G_W-1){1'b1}}};
        return v[G_W-1:0];
    endfunction

    // The mover negates via sign-magnitude, which has no +512; pull -512 in by one.
    function automatic logic signed [G_W-1:0] clamp_neg512(input logic signed [G_W-1:0] v);
        if (v == {1'b1, {(G_W-1){1'b0}}})
            return {1'b1, {(G_W-2){1'b0}}, 1'b1};
        return v;
    endfunction

endpackage

// File: rtl/accel_axis_avg.sv
// One axis: moving-average window, running sum, dead zone and output clamp.
module accel_axis_avg
    import accel_pkg::*;
#(
    parameter int AVG_LOG2 = 3,
    parameter int DEADZONE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic                  clr,
    input  logic signed [G_W-1:0] corr,
    output logic                  will_fill,
    output logic        [G_W-1:0] g
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = G_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0]       FULL = (AVG_LOG2+1)'(N);
    localparam logic signed [G_W-1:0]   DZ   = G_W'(DEADZONE);

    logic [N-1:0][G_W-1:0]  win;
    logic signed [SW-1:0]   sum, sum_next;
    logic [AVG_LOG2:0]      fill;
    logic signed [G_W-1:0]  avg, dz;

    // Next running sum, floor average (top bits of the sum), dead zone and clamp.
    always_comb begin
        sum_next  = sum + {{AVG_LOG2{corr[G_W-1]}}, corr}
                        - {{AVG_LOG2{win[N-1][G_W-1]}}, win[N-1]};
        avg       = sum_next[SW-1:AVG_LOG2];
        dz        = (avg < DZ && avg > -DZ) ? '0 : clamp_neg512(avg);
        will_fill = push && (fill >= FULL - 1'b1);
    end

    // Window shift, running sum, fill count and held output register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            win  <= '0;
            sum  <= '0;
            fill <= '0;
            g    <= '0;
        end else if (clr) begin
            win  <= '0;
            sum  <= '0;
            fill <= '0;
            g    <= '0;
        end else if (push) begin
            win <= {win[N-2:0], corr};
            sum <= sum_next;
            if (fill != FULL)
                fill <= fill + 1'b1;
            if (will_fill)
                g <= dz;
        end
    end

endmodule

// File: rtl/accel_tilt_filter.sv
// Tilt conditioner: offset calibration FSM feeding per-axis averaging lanes.
module accel_tilt_filter
    import accel_pkg::*;
#(
    parameter int AVG_LOG2 = 3,
    parameter int CAL_LOG2 = 4,
    parameter int DEADZONE = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           sample_valid,
    input  logic [G_W-1:0] x_raw,
    input  logic [G_W-1:0] y_raw,
    input  logic           cal_req,
    output logic [G_W-1:0] xAxisG,
    output logic [G_W-1:0] yAxisG,
    output logic           g_valid,
    output logic           cal_busy
);

    localparam int NUM_AXES = 2;
    localparam int AW       = G_W + CAL_LOG2;

    logic [NUM_AXES-1:0][G_W-1:0] raw, corr, g;
    logic [NUM_AXES-1:0]          will_fill;
    state_t                       state, state_next;
    logic [CAL_LOG2-1:0]          cal_cnt;
    logic                         run_push, cal_push, cal_done;

    assign raw      = {y_raw, x_raw};
    assign run_push = sample_valid && (state == RUN);
    assign cal_push = sample_valid && (state == CAL);
    assign cal_done = cal_push && (&cal_cnt);
    assign xAxisG   = g[0];
    assign yAxisG   = g[1];

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        logic [AW-1:0]  acc, acc_sum;
        logic [G_W-1:0] off;

        assign acc_sum = acc + {{CAL_LOG2{raw[i][G_W-1]}}, raw[i]};
        assign corr[i] = sat10({raw[i][G_W-1], raw[i]} - {off[i*0+G_W-1], off});

        // Calibration accumulator; the offset is the floor mean of the CAL samples.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                acc <= '0;
                off <= '0;
            end else if (cal_push) begin
                if (cal_done) begin
                    off <= acc_sum[AW-1:CAL_LOG2];
                    acc <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end

        accel_axis_avg #(.AVG_LOG2(AVG_LOG2), .DEADZONE(DEADZONE)) u_axis (
            .CLK       (CLK),
            .RST       (RST),
            .push      (run_push),
            .clr       (cal_done),
            .corr      (corr[i]),
            .will_fill (will_fill[i]),
            .g         (g[i])
        );
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= state_next;
    end

    // Next state: cal_req only honoured in RUN; CAL ends on its last strobe.
    always_comb begin
        state_next = state;
        case (state)
            RUN: if (cal_req)  state_next = CAL;
            CAL: if (cal_done) state_next = RUN;
            default:           state_next = RUN;
        endcase
    end

    // Output strobe, busy flag and calibration strobe counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            g_valid  <= 1'b0;
            cal_busy <= 1'b0;
            cal_cnt  <= '0;
        end else begin
            g_valid  <= run_push && (&will_fill);
            cal_busy <= (state_next == CAL);
            if (cal_push)
                cal_cnt <= cal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Directed bench for accel_tilt_filter with hand-computed expectations.
module tb_accel_tilt_filter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       sample_valid = 1'b0;
    logic [9:0] x_raw = '0;
    logic [9:0] y_raw = '0;
    logic       cal_req = 1'b0;
    logic [9:0] xAxisG, yAxisG;
    logic       g_valid, cal_busy;

    int checks = 0;
    int errors = 0;

    accel_tilt_filter dut (
        .CLK          (CLK),
        .RST          (RST),
        .sample_valid (sample_valid),
        .x_raw        (x_raw),
        .y_raw        (y_raw),
        .cal_req      (cal_req),
        .xAxisG       (xAxisG),
        .yAxisG       (yAxisG),
        .g_valid      (g_valid),
        .cal_busy     (cal_busy)
    );

    always #5 CLK = ~CLK;

    // One strobe; returns after the edge so outputs reflect this sample.
    task automatic strobe(input logic [9:0] x, input logic [9:0] y);
        @(negedge CLK);
        sample_valid = 1'b1;
        x_raw = x;
        y_raw = y;
        @(posedge CLK);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic pulse_cal;
        @(negedge CLK);
        cal_req = 1'b1;
        @(posedge CLK);
        #1;
        cal_req = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({xAxisG, yAxisG, g_valid, cal_busy} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state got x=%h y=%h v=%b b=%b want 0", xAxisG, yAxisG, g_valid, cal_busy);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_first_fill;
        int early = 0;
        for (int i = 0; i < 7; i++) begin
            strobe(10'd100, -10'sd100);
            if (g_valid) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL early_valid got %0d pulses want 0", early);
        end
        strobe(10'd100, -10'sd100);
        checks++;
        if (g_valid !== 1'b1 || xAxisG !== 10'd100 || yAxisG !== 10'h39C) begin
            errors++;
            $display("FAIL first_fill got v=%b x=%h y=%h want v=1 x=064 y=39c", g_valid, xAxisG, yAxisG);
        end
        @(posedge CLK); #1;
        checks++;
        if (g_valid !== 1'b0 || xAxisG !== 10'd100) begin
            errors++;
            $display("FAIL hold got v=%b x=%h want v=0 x=064", g_valid, xAxisG);
        end
    endtask

    task automatic test_deadzone;
        for (int i = 0; i < 8; i++) strobe(10'd7, 10'd0);
        checks++;
        if (g_valid !== 1'b1 || xAxisG !== 10'd0 || yAxisG !== 10'd0) begin
            errors++;
            $display("FAIL deadzone_7 got v=%b x=%h y=%h want v=1 x=000 y=000", g_valid, xAxisG, yAxisG);
        end
        for (int i = 0; i < 8; i++) strobe(10'h3F8, 10'd0);
        checks++;
        if (xAxisG !== 10'h3F8) begin
            errors++;
            $display("FAIL deadzone_edge got x=%h want 3f8", xAxisG);
        end
    endtask

    task automatic test_calibration;
        int vcnt = 0;
        int busy_bad = 0;
        pulse_cal;
        checks++;
        if (cal_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise got %b want 1", cal_busy);
        end
        for (int i = 0; i < 16; i++) begin
            strobe(10'd20, 10'h3F4);
            if (g_valid) vcnt++;
            if (i < 15 && cal_busy !== 1'b1) busy_bad++;
        end
        checks++;
        if (vcnt != 0 || busy_bad != 0 || cal_busy !== 1'b0) begin
            errors++;
            $display("FAIL cal_window got pulses=%0d busy_drops=%0d busy_end=%b want 0 0 0", vcnt, busy_bad, cal_busy);
        end
        checks++;
        if (xAxisG !== 10'd0 || yAxisG !== 10'd0) begin
            errors++;
            $display("FAIL cal_clear got x=%h y=%h want 000 000", xAxisG, yAxisG);
        end
        for (int i = 0; i < 8; i++) strobe(10'd20, 10'h3F4);
        checks++;
        if (g_valid !== 1'b1 || xAxisG !== 10'd0 || yAxisG !== 10'd0) begin
            errors++;
            $display("FAIL cal_offset got v=%b x=%h y=%h want v=1 x=000 y=000", g_valid, xAxisG, yAxisG);
        end
    endtask

    task automatic test_saturation;
        int bad = 0;
        pulse_cal;
        for (int i = 0; i < 16; i++) strobe(10'd300, 10'd0);
        for (int i = 0; i < 8; i++) begin
            strobe(10'h270, 10'd0);  // -400
            if (xAxisG === 10'h200) bad++;
        end
        checks++;
        if (bad != 0 || g_valid !== 1'b1 || xAxisG !== 10'h201 || yAxisG !== 10'd0) begin
            errors++;
            $display("FAIL sat_clamp got v=%b x=%h y=%h seen200=%0d want v=1 x=201 y=000 0", g_valid, xAxisG, yAxisG, bad);
        end
    endtask

    task automatic test_same_edge;
        do_reset;
        for (int i = 0; i < 7; i++) strobe(10'd0, 10'd0);
        @(negedge CLK);
        sample_valid = 1'b1;
        cal_req = 1'b1;
        x_raw = 10'd64;
        y_raw = 10'd0;
        @(posedge CLK); #1;
        sample_valid = 1'b0;
        cal_req = 1'b0;
        checks++;
        if (g_valid !== 1'b1 || xAxisG !== 10'd8 || cal_busy !== 1'b1) begin
            errors++;
            $display("FAIL same_edge got v=%b x=%h b=%b want v=1 x=008 b=1", g_valid, xAxisG, cal_busy);
        end
        for (int i = 0; i < 15; i++) strobe(10'd8, 10'd0);
        checks++;
        if (cal_busy !== 1'b1) begin
            errors++;
            $display("FAIL same_edge_15 got busy=%b want 1", cal_busy);
        end
        strobe(10'd8, 10'd0);
        checks++;
        if (cal_busy !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_16 got busy=%b want 0", cal_busy);
        end
        for (int i = 0; i < 8; i++) strobe(10'd50, 10'd0);
        checks++;
        if (xAxisG !== 10'd42) begin
            errors++;
            $display("FAIL offset_8 got x=%h want 02a", xAxisG);
        end
    endtask

    task automatic test_reset_mid_cal;
        pulse_cal;
        for (int i = 0; i < 5; i++) strobe(10'd0, 10'd0);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (cal_busy !== 1'b0 || xAxisG !== 10'd0 || yAxisG !== 10'd0) begin
            errors++;
            $display("FAIL async_reset got b=%b x=%h y=%h want 0 000 000", cal_busy, xAxisG, yAxisG);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 8; i++) strobe(10'd50, 10'd0);
        checks++;
        if (g_valid !== 1'b1 || xAxisG !== 10'd50) begin
            errors++;
            $display("FAIL post_reset got v=%b x=%h want v=1 x=032", g_valid, xAxisG);
        end
    endtask

    initial begin
        test_reset;
        test_first_fill;
        test_deadzone;
        test_calibration;
        test_saturation;
        test_same_edge;
        test_reset_mid_cal;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
